// File: rtl/ysyx_24070014_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM encoding and requester IDs.
package ysyx_24070014_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ysyx_24070014_IDLE  = 2'd0,
    ysyx_24070014_ISSUE = 2'd1,
    ysyx_24070014_WAIT  = 2'd2
  } ysyx_24070014_state_e;

  // Requester IDs double as bit positions in the arbiter request/grant vectors.
  localparam logic ysyx_24070014_ID_IFU = 1'b0;
  localparam logic ysyx_24070014_ID_LSU = 1'b1;

  localparam int ysyx_24070014_WMASK_W = 4;

endpackage

// File: rtl/ysyx_24070014_rr_arbiter2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
// Purely combinational; a lone request is always granted.
module ysyx_24070014_rr_arbiter2
  import ysyx_24070014_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[ysyx_24070014_ID_IFU] && req[ysyx_24070014_ID_LSU]) begin
      if (last_grant == ysyx_24070014_ID_LSU) gnt[ysyx_24070014_ID_IFU] = 1'b1;
      else                                    gnt[ysyx_24070014_ID_LSU] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Shares one memory port between IFU and LSU with a single outstanding transaction.
// Accept in IDLE, hold the latched request in ISSUE until taken, pass the response through in WAIT.
module ysyx_24070014_mem_arbiter
  import ysyx_24070014_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ifu_req_valid,
  output logic                             ifu_req_ready,
  input  logic [ADDR_LEN-1:0]              ifu_addr,
  output logic                             ifu_resp_valid,
  input  logic                             lsu_req_valid,
  output logic                             lsu_req_ready,
  input  logic [ADDR_LEN-1:0]              lsu_addr,
  input  logic [ysyx_24070014_WMASK_W-1:0] lsu_wmask,
  input  logic [DATA_LEN-1:0]              lsu_wdata,
  output logic                             lsu_resp_valid,
  output logic [DATA_LEN-1:0]              resp_rdata,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_LEN-1:0]              mem_addr,
  output logic [ysyx_24070014_WMASK_W-1:0] mem_wmask,
  output logic [DATA_LEN-1:0]              mem_wdata,
  input  logic                             mem_resp_valid,
  input  logic [DATA_LEN-1:0]              mem_rdata
);

  ysyx_24070014_state_e state_q, state_d;
  logic                             owner_q, owner_d;
  logic                             last_grant_q, last_grant_d;
  logic [ADDR_LEN-1:0]              addr_q, addr_d;
  logic [ysyx_24070014_WMASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_LEN-1:0]              wdata_q, wdata_d;
  logic [1:0]                       arb_req, arb_gnt;
  logic                             accept, grant_id, resp_hit;

  // Requests only reach the arbiter while idle and out of reset, so ready is never
  // raised while reset is held low.
  always_comb begin
    arb_req = 2'b00;
    if (reset && (state_q == ysyx_24070014_IDLE)) begin
      arb_req[ysyx_24070014_ID_IFU] = ifu_req_valid;
      arb_req[ysyx_24070014_ID_LSU] = lsu_req_valid;
    end
  end

  ysyx_24070014_rr_arbiter2 u_rr (
    .req        (arb_req),
    .last_grant (last_grant_q),
    .gnt        (arb_gnt)
  );

  assign accept   = |arb_gnt;
  assign grant_id = arb_gnt[ysyx_24070014_ID_LSU] ? ysyx_24070014_ID_LSU : ysyx_24070014_ID_IFU;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ysyx_24070014_IDLE;
      owner_q      <= ysyx_24070014_ID_IFU;
      last_grant_q <= ysyx_24070014_ID_LSU;
      addr_q       <= '0;
      wmask_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    case (state_q)
      ysyx_24070014_IDLE: begin
        if (accept) begin
          state_d      = ysyx_24070014_ISSUE;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          if (grant_id == ysyx_24070014_ID_LSU) begin
            addr_d  = lsu_addr;
            wmask_d = lsu_wmask;
            wdata_d = lsu_wdata;
          end else begin
            addr_d  = ifu_addr;
            wmask_d = '0;
            wdata_d = '0;
          end
        end
      end
      ysyx_24070014_ISSUE: if (mem_req_ready) state_d = ysyx_24070014_WAIT;
      ysyx_24070014_WAIT:  if (mem_resp_valid) state_d = ysyx_24070014_IDLE;
      default:             state_d = ysyx_24070014_IDLE;
    endcase
  end

  always_comb begin
    resp_hit       = (state_q == ysyx_24070014_WAIT) && mem_resp_valid;
    ifu_req_ready  = arb_gnt[ysyx_24070014_ID_IFU];
    lsu_req_ready  = arb_gnt[ysyx_24070014_ID_LSU];
    mem_req_valid  = (state_q == ysyx_24070014_ISSUE);
    mem_addr       = addr_q;
    mem_wmask      = wmask_q;
    mem_wdata      = wdata_q;
    ifu_resp_valid = resp_hit && (owner_q == ysyx_24070014_ID_IFU);
    lsu_resp_valid = resp_hit && (owner_q == ysyx_24070014_ID_LSU);
    resp_rdata     = resp_hit ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Randomised scoreboard bench for the IFU/LSU memory arbiter with a behavioural memory device.
module tb_ysyx_24070014_mem_arbiter;

  logic        clk = 1'b0, reset = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ysyx_24070014_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wmask(lsu_wmask), .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } txn_t;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Contents of the behavioural memory; the boot word sits at the reset vector.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // ---------------- reference model / scoreboard monitor ----------------
  txn_t req_q[$];   // accepted, not yet handed to memory
  txn_t rsp_q[$];   // accepted, response not yet delivered
  bit   exp_last = 1'b1;
  bit   glog[$];    // observed grant order, 1 = LSU
  int   seen_ifu = 0, seen_lsu = 0;

  always @(negedge clk) begin : monitor
    bit   busy, exp_rv, exp_iv, exp_lv, exp_ir, exp_lr;
    txn_t t;
    if (!reset) begin
      chk("rst_valid_ready", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wmask_wdata", {mem_wmask, mem_wdata}, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      req_q.delete();
      rsp_q.delete();
      exp_last = 1'b1;
    end else begin
      busy   = (rsp_q.size() != 0);
      exp_rv = busy && (req_q.size() == 0) && mem_resp_valid;
      exp_iv = 1'b0;
      exp_lv = 1'b0;
      if (exp_rv) begin
        exp_iv = !rsp_q[0].lsu;
        exp_lv = rsp_q[0].lsu;
      end
      chk("ifu_resp_valid", ifu_resp_valid, exp_iv);
      chk("lsu_resp_valid", lsu_resp_valid, exp_lv);
      if (ifu_resp_valid) seen_ifu++;
      if (lsu_resp_valid) seen_lsu++;
      if (exp_rv) begin
        t = rsp_q.pop_front();
        if (t.wmask == 4'b0000) chk("resp_rdata", resp_rdata, mem_val(t.addr));
      end else begin
        chk("resp_rdata_zero", resp_rdata, 0);
      end

      chk("mem_req_valid", mem_req_valid, req_q.size() != 0);
      if ((req_q.size() != 0) && mem_req_valid) begin
        chk("mem_addr", mem_addr, req_q[0].addr);
        chk("mem_wmask_wdata", {mem_wmask, mem_wdata}, {req_q[0].wmask, req_q[0].wdata});
        if (mem_req_ready) void'(req_q.pop_front());
      end

      exp_ir = 1'b0;
      exp_lr = 1'b0;
      if (!busy) begin
        if (ifu_req_valid && lsu_req_valid) begin
          if (exp_last) exp_ir = 1'b1;
          else          exp_lr = 1'b1;
        end else begin
          exp_ir = ifu_req_valid;
          exp_lr = lsu_req_valid;
        end
      end
      chk("ifu_req_ready", ifu_req_ready, exp_ir);
      chk("lsu_req_ready", lsu_req_ready, exp_lr);
      if (ifu_req_valid && ifu_req_ready) glog.push_back(1'b0);
      if (lsu_req_valid && lsu_req_ready) glog.push_back(1'b1);
      if (exp_ir || exp_lr) begin
        t.lsu   = exp_lr;
        t.addr  = exp_lr ? lsu_addr : ifu_addr;
        t.wmask = exp_lr ? lsu_wmask : 4'b0000;
        t.wdata = exp_lr ? lsu_wdata : 32'h0;
        req_q.push_back(t);
        rsp_q.push_back(t);
        exp_last = exp_lr;
      end
    end
  end

  // ---------------- requester drivers ----------------
  txn_t ifu_list[$], lsu_list[$];
  bit   ifu_fire = 1'b0, lsu_fire = 1'b0;
  int   valid_pct = 100;

  always @(negedge clk) begin
    ifu_fire = ifu_req_valid && ifu_req_ready;
    lsu_fire = lsu_req_valid && lsu_req_ready;
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      ifu_list.delete();
      lsu_list.delete();
    end else begin
      if (ifu_fire) begin ifu_req_valid = 1'b0; void'(ifu_list.pop_front()); end
      if (lsu_fire) begin lsu_req_valid = 1'b0; void'(lsu_list.pop_front()); end
      if (!ifu_req_valid && ifu_list.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
        ifu_req_valid = 1'b1;
        ifu_addr      = ifu_list[0].addr;
      end
      if (!lsu_req_valid && lsu_list.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
        lsu_req_valid = 1'b1;
        lsu_addr      = lsu_list[0].addr;
        lsu_wmask     = lsu_list[0].wmask;
        lsu_wdata     = lsu_list[0].wdata;
      end
    end
  end

  // ---------------- memory device ----------------
  int          rdy_lat = 0, resp_dly = 0, cnt = 0, wait_cnt = 0;
  bit          rdy_rand = 1'b0, resp_rand = 1'b0, spur_en = 1'b0, pend = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      pend      = 1'b1;
      pend_addr = mem_addr;
      cnt       = resp_rand ? int'($urandom_range(0, 2)) : resp_dly;
      wait_cnt  = 0;
    end else if (mem_req_valid) begin
      wait_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_resp_valid = 1'b0;
    mem_rdata      = $urandom();
    if (pend) begin
      if (cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = mem_val(pend_addr);
        pend           = 1'b0;
      end else begin
        cnt--;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_resp_valid = 1'b1;
    end
    mem_req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : (wait_cnt >= rdy_lat);
  end

  // ---------------- stimulus sequence ----------------
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((ifu_list.size() != 0 || lsu_list.size() != 0 || rsp_q.size() != 0 || pend) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_ifu(input logic [31:0] a);
    txn_t t;
    t.lsu = 1'b0; t.addr = a; t.wmask = 4'b0000; t.wdata = 32'h0;
    ifu_list.push_back(t);
  endtask

  task automatic push_lsu(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    txn_t t;
    t.lsu = 1'b1; t.addr = a; t.wmask = m; t.wdata = d;
    lsu_list.push_back(t);
  endtask

  initial begin : main
    int n, base;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Single fetch from the reset vector with an always-ready memory.
    @(negedge clk);
    seen_ifu = 0; seen_lsu = 0;
    push_ifu(32'h8000_0000);
    wait_idle("fetch_done", 50);
    chk("fetch_ifu_resp_count", seen_ifu, 1);
    chk("fetch_lsu_resp_count", seen_lsu, 0);

    // Back-to-back ties straight out of reset must alternate starting with IFU.
    do_reset();
    glog.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_ifu(32'h8000_0004);
      push_lsu(32'h8000_1000, 4'b0000, 32'h0);
    end
    wait_idle("tie_done", 100);
    chk("tie_grant_count", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("tie_grant_%0d", i), glog[i], i % 2);

    // Store held off by memory for three cycles, with stray responses during ISSUE.
    rdy_lat = 3; spur_en = 1'b1; seen_lsu = 0;
    push_lsu(32'h8000_1000, 4'b0011, 32'hDEAD_BEEF);
    wait_idle("store_done", 60);
    chk("store_ack_count", seen_lsu, 1);

    // Stray responses while idle must not produce anything.
    seen_ifu = 0; seen_lsu = 0;
    repeat (20) @(negedge clk);
    chk("spurious_idle_resp", seen_ifu + seen_lsu, 0);

    // Randomised traffic.
    valid_pct = 60; rdy_rand = 1'b1; resp_rand = 1'b1; rdy_lat = 0;
    for (int i = 0; i < 150; i++) begin
      push_ifu(32'h8000_0000 + 4 * $urandom_range(0, 255));
      push_lsu(32'h8000_0000 + 4 * $urandom_range(0, 255),
               ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000, $urandom());
    end
    wait_idle("random_done", 8000);

    // Reset during WAIT: the late memory response must be dropped.
    valid_pct = 100; rdy_rand = 1'b0; resp_rand = 1'b0; spur_en = 1'b0; resp_dly = 6;
    push_ifu(32'h8000_0040);
    n = 0;
    while (!pend && n < 50) begin @(negedge clk); n++; end
    chk("reached_wait", pend, 1);
    do_reset();
    base = seen_ifu + seen_lsu;
    n = 0;
    while (pend && n < 50) begin @(negedge clk); n++; end
    chk("late_resp_delivered_by_memory", pend, 0);
    repeat (2) @(negedge clk);
    chk("late_resp_dropped", seen_ifu + seen_lsu, base);

    // First tie after that reset goes to IFU.
    resp_dly = 0;
    glog.delete();
    push_ifu(32'h8000_0080);
    push_lsu(32'h8000_1080, 4'b0000, 32'h0);
    wait_idle("post_reset_tie_done", 50);
    chk("post_reset_tie_count", glog.size(), 2);
    if (glog.size() != 0) chk("post_reset_tie_first_ifu", glog[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_24070014_mem_arbiter.md
YSYX_24070014_MEM_ARBITER -- requirements
Module: ysyx_24070014_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ifu_req_valid  input  1  instruction-fetch read request.
REQ-006 SHALL have port ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  input  ADDR_LEN  fetch address.
REQ-008 SHALL have port ifu_resp_valid  output  1  fetch data valid on resp_rdata.
REQ-009 SHALL have port lsu_req_valid  input  1  load/store request.
REQ-010 SHALL have port lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-011 SHALL have port lsu_addr  input  ADDR_LEN  load/store address.
REQ-012 SHALL have port lsu_wmask  input  4  byte write mask; 4'b0000 means read.
REQ-013 SHALL have port lsu_wdata  input  DATA_LEN  store data.
REQ-014 SHALL have port lsu_resp_valid  output  1  load data valid / store acknowledged.
REQ-015 SHALL have port resp_rdata  output  DATA_LEN  read data shared by both requesters.
REQ-016 SHALL have port mem_req_valid  output  1  request to the single memory port.
REQ-017 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-018 SHALL have port mem_addr  output  ADDR_LEN  latched request address.
REQ-019 SHALL have port mem_wmask  output  4  latched write mask.
REQ-020 SHALL have port mem_wdata  output  DATA_LEN  latched write data.
REQ-021 SHALL have port mem_resp_valid  input  1  memory response valid.
REQ-022 SHALL have port mem_rdata  input  DATA_LEN  memory read data.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT; one outstanding transaction at a time.
REQ-024 IDLE: if any req_valid, SHALL assert exactly one req_ready combinationally, latch that requester's addr/wmask/wdata (IFU wmask forced 0, wdata 0), record owner, go ISSUE.
REQ-025 Both valid in IDLE SHALL grant the requester NOT granted last (round-robin); single valid SHALL be granted regardless of history.
REQ-026 req_ready SHALL be 0 in ISSUE and WAIT.
REQ-027 ISSUE: mem_req_valid=1 with latched fields held stable until mem_req_ready=1; that cycle SHALL go WAIT.
REQ-028 mem_resp_valid SHALL be ignored outside WAIT.
REQ-029 WAIT: on mem_resp_valid, owner's resp_valid SHALL be 1 that same cycle, resp_rdata=mem_rdata, FSM to IDLE; other resp_valid stays 0.
REQ-030 Stores SHALL also complete via mem_resp_valid (ack); resp_rdata content then undefined.
REQ-031 Minimum round trip: accept T, mem_req_valid T+1, response earliest T+2, next accept earliest T+3.
REQ-032 resp_rdata SHALL be 0 whenever no resp_valid is high.

Reset
REQ-033 reset low SHALL immediately force IDLE, all valid/ready outputs 0, mem_addr/mem_wmask/mem_wdata 0, last-grant = LSU (so IFU wins first tie); in-flight transaction dropped, no response delivered.
REQ-034 After reset rises, first grant SHALL occur no earlier than the next rising clk edge.

Structure
REQ-035 FSM state encoding and requester-ID constants SHALL live in the shared DEFINITION include, prefixed ysyx_24070014_.
REQ-036 Round-robin choice SHALL be a sub-module ysyx_24070014_rr_arbiter2 (2 requests, last-grant input, one-hot grant out); no other sub-modules.

Verification
REQ-037 IFU only, addr 0x80000000, mem ready immediately, rdata 0x00000413 one cycle later -> ifu_resp_valid 1 cycle with 0x00000413, lsu_resp_valid never high.
REQ-038 Both valid after reset (IFU 0x80000004, LSU 0x80001000 read) -> IFU granted first, then LSU; alternate for 4 back-to-back pairs.
REQ-039 LSU store addr 0x80001000, wmask 4'b0011, wdata 0xDEADBEEF, mem_req_ready low 3 cycles -> mem_* fields stable all 3 cycles, lsu_resp_valid on ack.
REQ-040 Spurious mem_resp_valid in IDLE and ISSUE -> no resp_valid, state unchanged.
REQ-041 Assert reset low during WAIT, then return mem_resp_valid -> no resp_valid, all outputs 0, next tie grants IFU.
